// File: rtl/bitserial_addsub_word.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, DIGIT bits per cycle.
// Sum digits are combinational (Mealy); carry-out, overflow and word_done are registered per word.
module bitserial_addsub_word #(
  parameter int DIGIT   = 1,
  parameter int WORDLEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             sub,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             out_valid,
  output logic [DIGIT-1:0] s,
  output logic             out_last,
  output logic             cout,
  output logic             ovf,
  output logic             word_done
);
  localparam int NDIG = WORDLEN / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            carry, mode;
  logic [CW-1:0]   dig_cnt;

  logic            first, accept, last;
  logic            m, cin, c_out, c_msb;
  logic [CW-1:0]   dig_cnt_eff;
  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]  sum;

  // A digit is consumed only when in_valid is high and it either opens a word
  // or continues one already running; there is no backpressure, so a consumed
  // digit always yields s in the same cycle.
  assign first       = in_valid & in_first;
  assign accept      = in_valid & (in_first | (state == RUN));
  assign dig_cnt_eff = in_first ? '0 : dig_cnt;
  assign last        = accept & (dig_cnt_eff == LAST_CNT);

  assign m     = in_first ? sub : mode;
  assign cin   = in_first ? sub : carry;
  assign bx    = b ^ {DIGIT{m}};
  assign sum   = {1'b0, a} + {1'b0, bx} + {{DIGIT{1'b0}}, cin};
  assign c_out = sum[DIGIT];
  // Carry into the top bit recovered from the top sum bit and its operands.
  assign c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ bx[DIGIT-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (first)  state_nxt = last ? IDLE : RUN;
      RUN:  if (accept) state_nxt = last ? IDLE : RUN;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    s         = '0;
    out_last  = 1'b0;
    if (accept) begin
      out_valid = 1'b1;
      s         = sum[DIGIT-1:0];
      out_last  = last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry     <= 1'b0;
      mode      <= 1'b0;
      dig_cnt   <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= last;
      if (accept) begin
        carry   <= c_out;
        dig_cnt <= last ? '0 : dig_cnt_eff + 1'b1;
      end
      if (first) mode <= sub;
      if (last) begin
        cout <= c_out;
        ovf  <= c_out ^ c_msb;
      end
    end
  end
endmodule

// File: tb/tb_bitserial_addsub_word.sv
// Bench for bitserial_addsub_word: DIGIT=1 instance scoreboarded digit by digit,
// plus DIGIT=4 and DIGIT=8 instances exercised directly.
module tb_bitserial_addsub_word;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       v1, f1, sub1, a1, b1;
  logic       ov1, s1, ol1, co1, ovf1, wd1;
  logic       v4, f4, sub4;
  logic [3:0] a4, b4, s4;
  logic       ov4, ol4, co4, ovf4, wd4;
  logic       v8, f8, sub8;
  logic [7:0] a8, b8, s8;
  logic       ov8, ol8, co8, ovf8, wd8;

  bitserial_addsub_word #(.DIGIT(1), .WORDLEN(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_first(f1), .sub(sub1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .out_last(ol1), .cout(co1), .ovf(ovf1), .word_done(wd1));
  bitserial_addsub_word #(.DIGIT(4), .WORDLEN(8)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_first(f4), .sub(sub4), .a(a4), .b(b4),
    .out_valid(ov4), .s(s4), .out_last(ol4), .cout(co4), .ovf(ovf4), .word_done(wd4));
  bitserial_addsub_word #(.DIGIT(8), .WORDLEN(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_first(f8), .sub(sub8), .a(a8), .b(b8),
    .out_valid(ov8), .s(s8), .out_last(ol8), .cout(co8), .ovf(ovf8), .word_done(wd8));

  int errors = 0;
  int checks = 0;
  int n_words = 0;
  int done_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] flag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver for the DIGIT=1 instance: n digits of the word, optional stall before digit stall_at.
  task automatic send_word(input logic [7:0] aw, input logic [7:0] bw, input logic sb,
                           input int n, input int stall_at, input int stall_len);
    logic [8:0] r;
    logic       eo;
    r  = sb ? ({1'b0, aw} + {1'b0, ~bw} + 9'd1) : ({1'b0, aw} + {1'b0, bw});
    eo = sb ? ((aw[7] != bw[7]) && (r[7] != aw[7])) : ((aw[7] == bw[7]) && (r[7] != aw[7]));
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int j = 0; j < stall_len; j++) begin
          v1 = 1'b0; f1 = 1'b0; a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("stall_out_valid", ov1, 0);
          check("stall_s", s1, 0);
          @(posedge clk); #1;
        end
      end
      v1 = 1'b1;
      f1 = (i == 0);
      sub1 = (i == 0) ? sb : ~sb;
      a1 = aw[i];
      b1 = bw[i];
      exp_q.push_back({(i == 7), r[i]});
      @(posedge clk); #1;
    end
    v1 = 1'b0; f1 = 1'b0;
    if (n == 8) begin
      flag_q.push_back({r[8], eo});
      n_words++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ov1) begin
        if (exp_q.size() == 0) check("unexpected_digit", 1, 0);
        else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("s_digit", s1, e[0]);
          check("out_last", ol1, e[1]);
        end
      end else begin
        check("idle_out_last", ol1, 0);
      end
      if (wd1) begin
        done_cnt++;
        if (flag_q.size() == 0) check("unexpected_word_done", 1, 0);
        else begin
          logic [1:0] e;
          e = flag_q.pop_front();
          check("cout", co1, e[1]);
          check("ovf", ovf1, e[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    v1 = 0; f1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    v4 = 0; f4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    v8 = 0; f8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", ov1, 0);
    check("rst_cout", co1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_word_done", wd1, 0);
    check("rst_word_done4", wd4, 0);
    check("rst_cout8", co8, 0);
    @(posedge clk); #1;

    send_word(8'h5A, 8'h3C, 1'b0, 8, -1, 0);
    send_word(8'hFF, 8'h01, 1'b0, 8, -1, 0);
    send_word(8'h10, 8'h20, 1'b1, 8, -1, 0);
    send_word(8'h80, 8'h01, 1'b1, 8, 4, 3);
    send_word(8'h55, 8'h55, 1'b0, 5, -1, 0);
    send_word(8'h01, 8'h01, 1'b0, 8, -1, 0);
    repeat (2) @(posedge clk); #1;

    send_word(8'hFF, 8'hFF, 1'b0, 4, -1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cout", co1, 0);
    check("post_rst_ovf", ovf1, 0);
    @(posedge clk); #1;
    v1 = 1'b1; f1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    check("nofirst_out_valid", ov1, 0);
    @(posedge clk); #1;
    v1 = 1'b0;
    send_word(8'h03, 8'h04, 1'b0, 8, -1, 0);

    for (int k = 0; k < 6; k++)
      send_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 8, (k == 2) ? 3 : -1, 2);
    repeat (3) @(posedge clk); #1;

    v4 = 1; f4 = 1; sub4 = 0; a4 = 4'hA; b4 = 4'hC;
    @(negedge clk);
    check("d4_valid0", ov4, 1);
    check("d4_s0", s4, 4'h6);
    check("d4_last0", ol4, 0);
    @(posedge clk); #1;
    f4 = 0; sub4 = 1; a4 = 4'h5; b4 = 4'h3;
    @(negedge clk);
    check("d4_s1", s4, 4'h9);
    check("d4_last1", ol4, 1);
    @(posedge clk); #1;
    v4 = 0;
    @(negedge clk);
    check("d4_done", wd4, 1);
    check("d4_cout", co4, 0);
    check("d4_ovf", ovf4, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("d4_done_pulse", wd4, 0);

    @(posedge clk); #1;
    v8 = 1; f8 = 1; sub8 = 0; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    check("d8_s", s8, 8'h80);
    check("d8_last", ol8, 1);
    @(posedge clk); #1;
    sub8 = 1; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    check("d8_done", wd8, 1);
    check("d8_cout", co8, 0);
    check("d8_ovf", ovf8, 1);
    check("d8_sub_s", s8, 8'hFF);
    check("d8_sub_last", ol8, 1);
    @(posedge clk); #1;
    v8 = 0;
    @(negedge clk);
    check("d8_sub_done", wd8, 1);
    check("d8_sub_cout", co8, 0);
    check("d8_sub_ovf", ovf8, 0);

    repeat (3) @(posedge clk); #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("flag_q_empty", flag_q.size(), 0);
    check("word_count", done_cnt, n_words);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
